// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency memory between the CPU fetch
// path and the load/store path. Each request is granted in IDLE, issued to
// memory for exactly one ACCESS cycle, waited out for MEM_LAT cycles, and
// completed with a one-cycle acknowledge in RESP.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   if_req_i, if_addr_i     fetch request / address (held until if_ack_o)
//   if_rdata_o, if_ack_o    fetched word (held between fetches), done pulse
//   d_req_i, d_we_i         data request, 1 = write
//   d_addr_i, d_wdata_i     data address / write data
//   d_rdata_o, d_ack_o      load data (held between loads), done pulse
//   mem_en_o, mem_we_o      memory strobe and write enable (ACCESS only)
//   mem_addr_o, mem_wdata_o memory address / write data (ACCESS only)
//   mem_rdata_i             memory read data, valid MEM_LAT cycles after mem_en_o
//   busy_o                  high whenever a transaction is in flight
//
// States:
//   IDLE   | no transaction; pick a winner among pending requests
//   ACCESS | mem_en_o asserted for one cycle, wait counter loaded
//   WAIT   | count down memory latency, capture read data on the last cycle
//   RESP   | pulse the granted port's acknowledge

module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MEM_LAT       = 1,
    parameter bit PRIORITY_DATA = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ack_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_ack_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    // Grant encoding: 0 = fetch port, 1 = data port.
    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic pick_data;

    // Data wins outright in fixed-priority mode; in round-robin mode it wins
    // when alone or when fetch was served last.
    assign pick_data = d_req_i &&
                       (PRIORITY_DATA || !if_req_i || (last_grant_q == GNT_FETCH));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_d = S_ACCESS;
                    if (pick_data) begin
                        grant_d      = GNT_DATA;
                        last_grant_d = GNT_DATA;
                        we_d         = d_we_i;
                        addr_d       = d_addr_i;
                        wdata_d      = d_wdata_i;
                    end else begin
                        grant_d      = GNT_FETCH;
                        last_grant_d = GNT_FETCH;
                        we_d         = 1'b0;
                        addr_d       = if_addr_i;
                        wdata_d      = '0;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d   = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (grant_q == GNT_DATA) begin
                            d_rdata_d = mem_rdata_i;
                        end else begin
                            if_rdata_d = mem_rdata_i;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= GNT_FETCH;
            last_grant_q <= GNT_FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Memory-side outputs are forced to zero outside ACCESS so the macro
    // never sees stale address or data.
    assign mem_en_o    = (state_q == S_ACCESS);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = mem_en_o ? addr_q  : '0;
    assign mem_wdata_o = mem_en_o ? wdata_q : '0;

    assign if_ack_o   = (state_q == S_RESP) && (grant_q == GNT_FETCH);
    assign d_ack_o    = (state_q == S_RESP) && (grant_q == GNT_DATA);
    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;

    // A: MEM_LAT=1 fixed priority; B: MEM_LAT=1 round-robin; C: MEM_LAT=3.
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
    logic [31:0] c_if_rdata, c_d_rdata, c_mem_addr, c_mem_wdata;
    logic        c_if_ack, c_d_ack, c_mem_en, c_mem_we, c_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .PRIORITY_DATA(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(a_if_rdata), .if_ack_o(a_if_ack),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(a_d_rdata), .d_ack_o(a_d_ack),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(a_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .PRIORITY_DATA(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(b_if_rdata), .if_ack_o(b_if_ack),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(b_d_rdata), .d_ack_o(b_d_ack),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(b_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .PRIORITY_DATA(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(c_if_rdata), .if_ack_o(c_if_ack),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(c_d_rdata), .d_ack_o(c_d_ack),
        .mem_en_o(c_mem_en), .mem_we_o(c_mem_we), .mem_addr_o(c_mem_addr),
        .mem_wdata_o(c_mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(c_busy)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_if_ack;
        logic        e_d_ack;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] dbe, bad, caf, mix, d12;
        dbe = 32'hDEADBEEF; bad = 32'h0BADF00D; caf = 32'hCAFE0001;
        mix = 32'hAAAA5555; d12 = 32'h12345678;
        //            ir    ia        dr    dw    da        dwd     mr              en    we    maddr     mwd     ia    da    ird   drd   busy
        vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0, dbe,          1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[3]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, dbe,   32'h0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, d12,   mix,          1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, d12,   mix,          1'b1, 1'b1, 32'h40, d12,   1'b0, 1'b0, dbe,   32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, d12,   mix,          1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   32'h0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, d12,   mix,          1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, dbe,   32'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   32'h0, 1'b0};
        vecs[10] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   32'h0, 1'b0};
        vecs[11] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0,        1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, dbe,   32'h0, 1'b1};
        vecs[12] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 32'h0, bad,          1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   32'h0, 1'b1};
        vecs[13] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, dbe,   bad,   1'b1};
        vecs[14] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   bad,   1'b0};
        vecs[15] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, dbe,   bad,   1'b1};
        vecs[16] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0, caf,          1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, dbe,   bad,   1'b1};
        vecs[17] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, caf,   bad,   1'b1};
        vecs[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, caf,   bad,   1'b0};

        // Reset state
        do_reset();
        #3;
        check("reset busy", 32'(a_busy), 32'h0);
        check("reset mem_en", 32'(a_mem_en), 32'h0);
        check("reset if_ack", 32'(a_if_ack), 32'h0);
        check("reset d_ack", 32'(a_d_ack), 32'h0);
        check("reset if_rdata", a_if_rdata, 32'h0);
        check("reset d_rdata", a_d_rdata, 32'h0);
        check("reset mem_addr", a_mem_addr, 32'h0);
        step();

        // Fetch read, data write, priority conflict on instance A
        for (int i = 0; i < 19; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            mem_rdata = vecs[i].mem_rdata;
            #4;
            check($sformatf("v%0d mem_en", i), 32'(a_mem_en), 32'(vecs[i].e_mem_en));
            check($sformatf("v%0d mem_we", i), 32'(a_mem_we), 32'(vecs[i].e_mem_we));
            check($sformatf("v%0d mem_addr", i), a_mem_addr, vecs[i].e_mem_addr);
            check($sformatf("v%0d mem_wdata", i), a_mem_wdata, vecs[i].e_mem_wdata);
            check($sformatf("v%0d if_ack", i), 32'(a_if_ack), 32'(vecs[i].e_if_ack));
            check($sformatf("v%0d d_ack", i), 32'(a_d_ack), 32'(vecs[i].e_d_ack));
            check($sformatf("v%0d if_rdata", i), a_if_rdata, vecs[i].e_if_rdata);
            check($sformatf("v%0d d_rdata", i), a_d_rdata, vecs[i].e_d_rdata);
            check($sformatf("v%0d busy", i), 32'(a_busy), 32'(vecs[i].e_busy));
            step();
        end

        // Reset in the middle of a read aborts it on instance A
        begin
            int lat;
            bit got;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
            step();                          // IDLE -> ACCESS
            step();                          // ACCESS -> WAIT
            mem_rdata = 32'h77777777;
            #2 rst = 1'b1;
            #1;
            check("abort busy", 32'(a_busy), 32'h0);
            check("abort mem_en", 32'(a_mem_en), 32'h0);
            check("abort if_rdata", a_if_rdata, 32'h0);
            check("abort d_rdata", a_d_rdata, 32'h0);
            check("abort d_ack", 32'(a_d_ack), 32'h0);
            d_req = 1'b0;
            #1 rst = 1'b0;
            step();
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #4;
                if (a_d_ack || a_if_ack) got = 1'b1;
                step();
            end
            check("abort no ack", 32'(got), 32'h0);
            if_req = 1'b1; if_addr = 32'h60; mem_rdata = 32'h13572468;
            lat = 0;
            got = 1'b0;
            while (lat < 10 && !got) begin
                #4;
                if (a_if_ack) got = 1'b1;
                else begin
                    step();
                    lat++;
                end
            end
            check("post-abort ack seen", 32'(got), 32'h1);
            check("post-abort latency", 32'(lat), 32'd3);
            check("post-abort if_rdata", a_if_rdata, 32'h13572468);
            step();
            if_req = 1'b0;
            step();
        end

        // Round-robin on instance B with both ports always requesting
        begin
            logic grants[6];
            int   n_gnt;
            int   cyc;
            logic prev_en;
            bit   bad_both, bad_en;
            do_reset();
            if_req = 1'b1; if_addr = 32'h100;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
            n_gnt = 0; cyc = 0; prev_en = 1'b0; bad_both = 1'b0; bad_en = 1'b0;
            while (n_gnt < 6 && cyc < 40) begin
                mem_rdata = 32'(cyc);
                #4;
                if (b_if_ack && b_d_ack) bad_both = 1'b1;
                if (prev_en && b_mem_en) bad_en = 1'b1;
                prev_en = b_mem_en;
                if (b_d_ack) begin grants[n_gnt] = 1'b1; n_gnt++; end
                else if (b_if_ack) begin grants[n_gnt] = 1'b0; n_gnt++; end
                step();
                cyc++;
            end
            if_req = 1'b0; d_req = 1'b0;
            check("rr grant count", 32'(n_gnt), 32'd6);
            check("rr cycles", 32'(cyc), 32'd24);
            check("rr double ack", 32'(bad_both), 32'h0);
            check("rr mem_en back-to-back", 32'(bad_en), 32'h0);
            for (int g = 0; g < n_gnt; g++)
                check($sformatf("rr grant %0d is data", g), 32'(grants[g]), 32'((g % 2) == 0));
            step();
        end

        // MEM_LAT=3 on instance C: only the last WAIT cycle's data is taken
        begin
            logic [31:0] mr_seq[7];
            mr_seq[0] = 32'h11111111; mr_seq[1] = 32'h11111111;
            mr_seq[2] = 32'h22222222; mr_seq[3] = 32'h33333333;
            mr_seq[4] = 32'h44444444; mr_seq[5] = 32'h55555555;
            mr_seq[6] = 32'h55555555;
            do_reset();
            for (int c = 0; c < 7; c++) begin
                if_req = (c < 6); if_addr = 32'h30; d_req = 1'b0;
                mem_rdata = mr_seq[c];
                #4;
                check($sformatf("lat3 c%0d mem_en", c), 32'(c_mem_en), 32'(c == 1));
                check($sformatf("lat3 c%0d if_ack", c), 32'(c_if_ack), 32'(c == 5));
                check($sformatf("lat3 c%0d busy", c), 32'(c_busy), 32'(c >= 1 && c <= 5));
                if (c == 1) check("lat3 mem_addr", c_mem_addr, 32'h30);
                if (c == 5) check("lat3 if_rdata", c_if_rdata, 32'h44444444);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency instruction/data memory between the CPU instruction-fetch path and the load/store path. It arbitrates the two requesters, sequences each memory access through a small FSM, and returns read data with a one-cycle acknowledge. It sits between single_cycle_cpu's fetch and load/store interfaces and the unified memory macro. It lets the CPU stall cleanly on shared-port conflicts.

Parameters:
AW, 32, address width (bits)
DW, 32, data width (bits)
MEM_LAT, 1, memory read latency in cycles from mem_en cycle to valid mem_rdata; legal 1..15
PRIORITY_DATA, 1, 1 = data port always wins conflicts; 0 = round-robin

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched word, valid when if_ack=1, held otherwise
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_rdata  out  DW  load data, valid when d_ack=1, held otherwise
d_ack  out  1  one-cycle data completion pulse
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  1 whenever state != IDLE

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Wait counter is 4 bits wide.
- Reset (async, immediate): state=IDLE, all outputs 0, if_rdata=d_rdata=0, last_grant=FETCH, counter=0.
- IDLE: if any req, choose winner, latch its addr/we/wdata (fetch: we=0, wdata=0) and grant id into internal registers; next state ACCESS. With no requests, stay in IDLE.
- Winner selection: PRIORITY_DATA=1 means d_req wins whenever asserted. PRIORITY_DATA=0 means a single requester wins; on conflict, the port not in last_grant wins. last_grant updates on every grant.
- ACCESS (1 cycle): mem_en=1, mem_we/mem_addr/mem_wdata driven from latched registers; counter loads MEM_LAT; next state WAIT.
- WAIT: counter decrements each cycle. In the cycle where the counter reaches 1, mem_rdata is valid. At that edge, capture mem_rdata into the granted port's rdata register (reads only; writes leave rdata unchanged); next state RESP.
- RESP (1 cycle): granted port's ack=1; next state IDLE. The other ack stays 0.
- Requester contract: hold req and fields stable until ack is seen; deassert on the edge after ack. IDLE re-samples only after RESP, so a held req is treated as a new request.
- Latency req-to-ack = MEM_LAT+2 cycles for an uncontended request (cycle0 IDLE grant, cycle1 ACCESS, MEM_LAT WAIT cycles, RESP).
- mem_en/mem_we/mem_addr/mem_wdata are 0 outside ACCESS. mem_en is never high on two consecutive cycles.
- A request arriving while busy waits; the losing request stays pending and is granted in the next IDLE.
- Reset during ACCESS/WAIT/RESP aborts the transaction: no ack is issued, and rdata goes to 0.
- Requests with MEM_LAT outside 1..15 are illegal (elaboration-time check).

Test Plan:
- Reset, MEM_LAT=1, if_req with if_addr=0x10, mem returns 0xDEADBEEF -> mem_en exactly at cycle 1 with mem_addr=0x10, mem_we=0; if_ack=1 at cycle 3 with if_rdata=0xDEADBEEF; busy=1 for cycles 1..3.
- d_req, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> one mem_en cycle with mem_we=1, mem_wdata=0x12345678; d_ack at cycle 3; d_rdata unchanged.
- PRIORITY_DATA=1, if_req and d_req both asserted at cycle 0 -> data serviced first (d_ack cycle 3); fetch granted at cycle 4 IDLE, if_ack cycle 7.
- PRIORITY_DATA=0, both requesters asserting continuously, three transactions each -> grants alternate D, F, D, F, ... starting with data; no ack is ever missed.
- MEM_LAT=3, single read -> ack 5 cycles after req; mem_rdata sampled at WAIT's final edge only (change mem_rdata earlier: not captured).
- rst pulsed during WAIT of a read -> outputs 0 asynchronously, no ack; after release, a fresh req completes normally.
